timer_control: RTL

TIMER_CONTROL -- requirements
Module: timer_control

---
 rtl/timer_control_pkg.sv | 24 ++
 rtl/timer_control_bcd_countdown.sv | 99 +++++++++
 rtl/timer_control.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/timer_control_pkg.sv
// ---------------------------------------------------------------------------
// timer_control_pkg
// Shared definitions for the microwave cook timer: controller state encoding,
// BCD digit limits and a small digit-validity helper.
// ---------------------------------------------------------------------------
package timer_control_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PROGRAM = 3'd1,
        ST_COOKING = 3'd2,
        ST_PAUSED  = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] SEC_T_RELOAD = 4'd5;

    // A keypad code is a usable BCD digit only in the range 0..DIGIT_MAX.
    function automatic logic digit_legal(input logic [3:0] d);
        return (d <= DIGIT_MAX);
    endfunction

endpackage

// File: rtl/timer_control_bcd_countdown.sv
// ---------------------------------------------------------------------------
// bcd_countdown
// Three-digit BCD time register (m:ts:us) with shift-in loading, clear and
// a one-second decrement with borrow.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   clr          : clear all digits to 0:00
//   load         : shift digit in at the units position
//   load_clear   : with load, clear the old digits before shifting in
//   digit        : BCD digit to shift in (caller guarantees 0..9)
//   dec          : decrement by one second
//   min, sec_t, sec_on : current digits
//   zero         : time is 0:00
//   last         : time is 0:01 (the next decrement reaches 0:00)
// Priority when several commands coincide: clr > load > dec.
// ---------------------------------------------------------------------------
module bcd_countdown
    import timer_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       load,
    input  logic       load_clear,
    input  logic [3:0] digit,
    input  logic       dec,
    output logic [3:0] min,
    output logic [3:0] sec_t,
    output logic [3:0] sec_on,
    output logic       zero,
    output logic       last
);

    logic [3:0] min_r, sec_t_r, sec_on_r;
    logic [3:0] min_s, sec_t_s, sec_on_s;

    assign zero = (min_r == 4'd0) && (sec_t_r == 4'd0) && (sec_on_r == 4'd0);
    assign last = (min_r == 4'd0) && (sec_t_r == 4'd0) && (sec_on_r == 4'd1);

    // Next-digit selection: clear, shift-in load, or borrow-chain decrement.
    always_comb begin
        min_s    = min_r;
        sec_t_s  = sec_t_r;
        sec_on_s = sec_on_r;
        if (clr) begin
            min_s    = 4'd0;
            sec_t_s  = 4'd0;
            sec_on_s = 4'd0;
        end else if (load) begin
            if (load_clear) begin
                min_s   = 4'd0;
                sec_t_s = 4'd0;
            end else begin
                min_s   = sec_t_r;
                sec_t_s = sec_on_r;
            end
            sec_on_s = digit;
        end else if (dec) begin
            // 0:00 holds so a stray decrement can never wrap a digit past 9.
            if (sec_on_r != 4'd0) begin
                sec_on_s = sec_on_r - 4'd1;
            end else if (sec_t_r != 4'd0) begin
                sec_t_s  = sec_t_r - 4'd1;
                sec_on_s = DIGIT_MAX;
            end else if (min_r != 4'd0) begin
                min_s    = min_r - 4'd1;
                sec_t_s  = SEC_T_RELOAD;
                sec_on_s = DIGIT_MAX;
            end else begin
                min_s    = 4'd0;
                sec_t_s  = 4'd0;
                sec_on_s = 4'd0;
            end
        end else begin
            min_s    = min_r;
            sec_t_s  = sec_t_r;
            sec_on_s = sec_on_r;
        end
    end

    // Digit register file.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            min_r    <= 4'd0;
            sec_t_r  <= 4'd0;
            sec_on_r <= 4'd0;
        end else begin
            min_r    <= min_s;
            sec_t_r  <= sec_t_s;
            sec_on_r <= sec_on_s;
        end
    end

    assign min    = min_r;
    assign sec_t  = sec_t_r;
    assign sec_on = sec_on_r;

endmodule

// File: rtl/timer_control.sv
// ---------------------------------------------------------------------------
// timer_control
// Microwave cook-timer controller: keypad entry of m:ss, start/pause/clear,
// door interlock and a 1 Hz countdown driving the magnetron enable.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   tick_1hz     : one-cycle pulse per second
//   key_valid    : one-cycle pulse qualifying key_digit
//   key_digit    : BCD key code, codes above 9 are ignored
//   start        : start / resume pulse
//   stop_clear   : pause (while cooking) or clear (otherwise) pulse
//   door_closed  : level, 1 = door closed
//   min, sec_t, sec_on : displayed digits (registered)
//   mag_on       : magnetron enable, high only while cooking (registered)
//   done         : high while the finished state is held (registered)
// Per-cycle priority: stop_clear > door open > start > tick > key.
// ---------------------------------------------------------------------------
module timer_control
    import timer_control_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic       key_valid,
    input  logic [3:0] key_digit,
    input  logic       start,
    input  logic       stop_clear,
    input  logic       door_closed,
    output logic [3:0] min,
    output logic [3:0] sec_t,
    output logic [3:0] sec_on,
    output logic       mag_on,
    output logic       done
);

    state_t state_r, state_s;
    logic   clr_s, load_s, load_clear_s, dec_s;
    logic   zero_s, last_s;
    logic   key_ok_s, can_start_s;
    logic   mag_on_r, done_r;

    assign key_ok_s    = key_valid && digit_legal(key_digit);
    assign can_start_s = start && door_closed && !zero_s;

    bcd_countdown u_count (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (clr_s),
        .load       (load_s),
        .load_clear (load_clear_s),
        .digit      (key_digit),
        .dec        (dec_s),
        .min        (min),
        .sec_t      (sec_t),
        .sec_on     (sec_on),
        .zero       (zero_s),
        .last       (last_s)
    );

    // Next-state and digit-command decode, highest-priority event first.
    always_comb begin
        state_s      = state_r;
        clr_s        = 1'b0;
        load_s       = 1'b0;
        load_clear_s = 1'b0;
        dec_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // stop_clear owns the cycle here even though it does nothing.
                if (stop_clear) begin
                    state_s = ST_IDLE;
                end else if (key_ok_s) begin
                    load_s  = 1'b1;
                    state_s = ST_PROGRAM;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_PROGRAM: begin
                if (stop_clear) begin
                    clr_s   = 1'b1;
                    state_s = ST_IDLE;
                end else if (can_start_s) begin
                    state_s = ST_COOKING;
                end else if (key_ok_s) begin
                    load_s  = 1'b1;
                    state_s = ST_PROGRAM;
                end else begin
                    state_s = ST_PROGRAM;
                end
            end
            ST_COOKING: begin
                if (stop_clear || !door_closed) begin
                    state_s = ST_PAUSED;
                end else if (tick_1hz) begin
                    dec_s   = 1'b1;
                    state_s = last_s ? ST_DONE : ST_COOKING;
                end else begin
                    state_s = ST_COOKING;
                end
            end
            ST_PAUSED: begin
                // A tick coinciding with resume is dropped: no decrement here.
                if (stop_clear) begin
                    clr_s   = 1'b1;
                    state_s = ST_IDLE;
                end else if (can_start_s) begin
                    state_s = ST_COOKING;
                end else begin
                    state_s = ST_PAUSED;
                end
            end
            ST_DONE: begin
                if (stop_clear) begin
                    clr_s   = 1'b1;
                    state_s = ST_IDLE;
                end else if (key_ok_s) begin
                    load_s       = 1'b1;
                    load_clear_s = 1'b1;
                    state_s      = ST_PROGRAM;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: begin
                clr_s   = 1'b1;
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register and registered status outputs (decoded from next state
    // so they change on the same edge as the state).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            mag_on_r <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            mag_on_r <= (state_s == ST_COOKING);
            done_r   <= (state_s == ST_DONE);
        end
    end

    assign mag_on = mag_on_r;
    assign done   = done_r;

endmodule
